// File: rtl/trans_fifo.sv
// Transactional FIFO: the writer and the reader each work speculatively
// and then commit or roll back. Committed writes become visible to the reader.
// Committed pops free their slots for the writer.
// dataOut is first-word-fall-through from a synchronously read memory.
module trans_fifo #(
   parameter int ADDR_WID = 9,
   parameter int DATA_WID = 8
) (
   input  logic                CLK,
   input  logic                rst,
   input  logic                dataValid,
   input  logic [DATA_WID-1:0] dataIn,
   input  logic                fillTransDone,
   input  logic                fillTransSuccess,
   output logic                full,
   output logic                fillOverflow,
   input  logic                popData,
   input  logic                popTransDone,
   input  logic                popTransSuccess,
   output logic                dataAvailable,
   output logic [DATA_WID-1:0] dataOut,
   output logic [ADDR_WID:0]   readableCount,
   output logic [ADDR_WID:0]   freeCount
);

   localparam int                DEPTH   = 1 << ADDR_WID;
   localparam logic [ADDR_WID:0] DEPTH_P = {1'b1, {ADDR_WID{1'b0}}};
   localparam logic [ADDR_WID:0] PTR_ONE = {{ADDR_WID{1'b0}}, 1'b1};

   // Pointers carry a wrap bit above the index, so full and empty are distinguishable.
   logic [ADDR_WID:0]   wcommit, wspec, rcommit, rspec, rspec_nxt;
   logic [ADDR_WID:0]   wused;
   logic                drop, overflow_q;
   logic                wr_fire, pop_fire;
   logic [DATA_WID-1:0] mem [DEPTH];
   logic [DATA_WID-1:0] rd_data_p1;
   logic                vld_p1;

   // wused counts the slots the writer holds: unreleased committed words plus speculative writes.
   assign wused    = wspec - rcommit;
   assign full     = (wused == DEPTH_P);
   // A transaction end takes priority over a handshake in the same cycle.
   assign wr_fire  = dataValid && !full && !fillTransDone;
   assign pop_fire = popData && vld_p1 && !popTransDone;

   assign readableCount = wcommit - rspec;
   assign freeCount     = DEPTH_P - wused;
   assign fillOverflow  = overflow_q;
   assign dataAvailable = vld_p1;
   assign dataOut       = rd_data_p1;

   // Next read pointer. The memory is addressed with this value so the output never bubbles.
   always_comb begin
      rspec_nxt = rspec;
      if (popTransDone) begin
         rspec_nxt = popTransSuccess ? rspec : rcommit;
      end else if (pop_fire) begin
         rspec_nxt = rspec + PTR_ONE;
      end
   end

   // Write side: speculative pointer, commit/rollback, and the drop flag for overflowed writes.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wcommit    <= '0;
         wspec      <= '0;
         drop       <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= fillTransDone && drop;
         if (fillTransDone) begin
            if (fillTransSuccess && !drop) begin
               wcommit <= wspec;
            end else begin
               wspec <= wcommit;
            end
            drop <= 1'b0;
         end else if (dataValid) begin
            if (full) begin
               drop <= 1'b1;
            end else begin
               wspec <= wspec + PTR_ONE;
            end
         end
      end
   end

   // Read side: speculative pointer follows rspec_nxt; a successful end releases the popped words.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         rspec   <= '0;
         rcommit <= '0;
      end else begin
         rspec <= rspec_nxt;
         if (popTransDone && popTransSuccess) begin
            rcommit <= rspec;
         end
      end
   end

   // Storage write port. Contents are deliberately left untouched by reset.
   always_ff @(posedge CLK) begin
      if (wr_fire) begin
         mem[wspec[ADDR_WID-1:0]] <= dataIn;
      end
   end

   // Stage p1: registered read port. It reloads every cycle from the next read address.
   always_ff @(posedge CLK) begin
      rd_data_p1 <= mem[rspec_nxt[ADDR_WID-1:0]];
   end

   // Stage p1 valid: the loaded word is valid only if it was committed before this cycle.
   // This also makes a freshly written address that is not yet committed read as invalid.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= (rspec_nxt != wcommit);
      end
   end

endmodule
